ripple_count_monitor: RTL and testbench
=======================================

# ripple_count_monitor

Synchronous consumer for the 4-bit output of the asynchronous mod-16 ripple counter. Resynchronises and de-glitches the ripple value into the system clock domain, extends it to a wide running count using modulo-16 deltas, flags wrap-arounds and missed counts, and publishes one record per wrap over a valid/ready handshake. Sits directly downstream of the ripple counter, between it and any synchronous logic that reads the count.

## Interface
- `EXT_W`, 16, width of the extended count (≥ 5).
- `STABLE_N`, 2, consecutive identical synchronised samples required before a value is accepted (≥ 1).
- `MAX_STEP`, 4, largest legal modulo-16 delta between accepted values (1..15).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `q_in`  in  4  ripple-counter value, asynchronous to `clk`.
- `clear`  in  1  synchronous soft clear.
- `count_out`  out  EXT_W  extended count.
- `locked`  out  1  baseline captured (state RUN).
- `wrap_pulse`  out  1  one-cycle pulse per detected 15→0 crossing.
- `delta_err`  out  1  sticky: accepted delta exceeded `MAX_STEP`.
- `ev_valid`  out  1  wrap record available.
- `ev_ready`  in  1  consumer accepts the record.
- `ev_data`  out  EXT_W  `count_out` value after the wrap update.
- `ev_overrun`  out  1  sticky: wrap lost because the record slot was full.

## Operation
- Input path: two-flop synchroniser `s1`→`s2`; a stability counter counts consecutive cycles with `s2` unchanged; a value is accepted once it has been seen `STABLE_N` times in a row.
- FSM: INIT, RUN.
  - INIT: first accepted value stored as `last`; no count update; go to RUN; `locked`=1.
  - RUN: accepted value `v` ≠ `last`: `delta = (v - last) mod 16` (4-bit unsigned); `count_out += delta`, wrapping mod 2^EXT_W; `last` = `v`. Accepted `v` == `last`: no action.
- Wrap: in RUN, `v < last` numerically means the value crossed 15→0, so `wrap_pulse`=1 for one cycle. A delta > 15 cannot be represented; multiple laps between samples are undetectable.
- Delta check: delta > `MAX_STEP` sets `delta_err`; the delta is still added.
- Record slot (one entry): a wrap loads `ev_data` = the new `count_out` and sets `ev_valid`. `ev_valid`/`ev_data` hold until `ev_valid && ev_ready`.
  - Wrap while `ev_valid && !ev_ready`: slot unchanged; `ev_overrun` set.
  - Wrap in the same cycle as an accept: new record loaded; `ev_valid` stays 1; no overrun.
- `clear` or `rst`:
  - All outputs go to 0 and the FSM returns to INIT.
  - `rst` additionally zeroes `s1`, `s2`, `last` and the stability counter.
  - `clear` keeps the synchroniser contents but restarts stability counting.
  - Either one, asserted mid-operation, discards a pending record without raising overrun.

## Timing
- Edge 0 = first `clk` edge sampling the new `q_in` into `s1`. The value reaches `s2` at edge 1. It is accepted, with `count_out`, `wrap_pulse` and `ev_valid` updated, at edge `STABLE_N`+1 (edge 3 by default).
- Throughput: at most one accepted value per `STABLE_N` cycles. The ripple source must hold each value ≥ `STABLE_N`+2 cycles.
- Reset values: `count_out`=0, `locked`=0, `wrap_pulse`=0, `delta_err`=0, `ev_valid`=0, `ev_data`=0, `ev_overrun`=0.
- `ev_ready` is sampled only while `ev_valid`=1. Outputs are registered, with no combinational path from `ev_ready` to `ev_valid`.

## Configuration
- `RCM_DELTA_CHECK_EN` defined: `MAX_STEP` comparison and sticky `delta_err` are built in.
- Not defined: comparator is omitted; `delta_err` is tied to 0; `MAX_STEP` is ignored; all other behaviour is identical.

## Test plan
- Reset, then `q_in`=5 held: `locked`=1 at edge 3, `count_out`=0; then `q_in`=6 gives `count_out`=1 at edge 3 after the change.
- Step `q_in` 14→15→0→1, each held 6 cycles: `count_out` rises by 1 per step; `wrap_pulse` fires once on 15→0; `ev_valid`=1 with `ev_data`=count after wrap.
- With `ev_ready`=0, force two wraps: first record retained, `ev_overrun`=1; `ev_ready`=1 then drops `ev_valid` next edge.
- Jump `q_in` 2→10 (delta 8, `MAX_STEP`=4): `count_out` +8; `delta_err`=1 with the macro defined, 0 without.
- 1-cycle glitch `q_in` 3→7→3: no acceptance of 7; `count_out` unchanged.
- `count_out`=2^EXT_W−1 plus delta 1 wraps to 0. Then pulse `clear`: all outputs are 0 on the next edge, and the next stable value re-baselines.

Source files
------------

// File: rtl/ripple_count_monitor.sv
// Resyncs/de-glitches a mod-16 ripple count, extends it to EXT_W bits, publishes one record per wrap.
// Accept latency STABLE_N+1 clks; 1-entry record slot, overflow sets ev_overrun; RCM_DELTA_CHECK_EN adds delta_err.
module ripple_count_monitor #(
  parameter int EXT_W    = 16,
  parameter int STABLE_N = 2,
  parameter int MAX_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       q_in,
  input  logic             clear,
  output logic [EXT_W-1:0] count_out,
  output logic             locked,
  output logic             wrap_pulse,
  output logic             delta_err,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [EXT_W-1:0] ev_data,
  output logic             ev_overrun
);

  localparam int CNT_W = (STABLE_N < 2) ? 1 : $clog2(STABLE_N + 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [3:0]       s1, s2, cand, last;
  logic [1:0]       fill;
  logic [CNT_W-1:0] stab_cnt;
  logic             restart, accept, wrap, step_err;
  logic [3:0]       delta;
  logic [EXT_W-1:0] count_nxt;

  // fill[1] marks s2 as holding a real sample rather than its reset value
  always_comb begin
    restart   = (stab_cnt == '0) || (s2 != cand);
    accept    = fill[1] && (restart ? (STABLE_N == 1) : (stab_cnt == CNT_W'(STABLE_N - 1)));
    delta     = s2 - last;
    count_nxt = count_out + EXT_W'(delta);
    wrap      = (state == RUN) && accept && (s2 < last);
`ifdef RCM_DELTA_CHECK_EN
    step_err  = (state == RUN) && accept && (delta > 4'(MAX_STEP));
`else
    step_err  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      fill       <= '0;
      cand       <= '0;
      stab_cnt   <= '0;
      last       <= '0;
      state      <= INIT;
      count_out  <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      delta_err  <= 1'b0;
      ev_valid   <= 1'b0;
      ev_data    <= '0;
      ev_overrun <= 1'b0;
    end else begin
      s1         <= q_in;
      s2         <= s1;
      fill       <= {fill[0], 1'b1};
      wrap_pulse <= 1'b0;
      if (clear) begin
        stab_cnt   <= '0;
        state      <= INIT;
        count_out  <= '0;
        locked     <= 1'b0;
        delta_err  <= 1'b0;
        ev_valid   <= 1'b0;
        ev_data    <= '0;
        ev_overrun <= 1'b0;
      end else begin
        if (fill[1]) begin
          if (restart) begin
            cand     <= s2;
            stab_cnt <= CNT_W'(1);
          end else if (stab_cnt != CNT_W'(STABLE_N)) begin
            stab_cnt <= stab_cnt + CNT_W'(1);
          end
        end
        if (accept) begin
          last <= s2;
          if (state == INIT) begin
            state  <= RUN;
            locked <= 1'b1;
          end else begin
            count_out  <= count_nxt;
            wrap_pulse <= wrap;
            if (step_err) delta_err <= 1'b1;
          end
        end
        // a wrap landing on the handshake cycle reloads the slot instead of overrunning
        if (ev_valid && ev_ready) ev_valid <= 1'b0;
        if (wrap) begin
          if (!ev_valid || ev_ready) begin
            ev_valid <= 1'b1;
            ev_data  <= count_nxt;
          end else begin
            ev_overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor; expected wraps and records are queued and checked by a monitor.
module tb_ripple_count_monitor;
  localparam int W = 8;
`ifdef RCM_DELTA_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst, clear, ev_ready;
  logic [3:0]   q_in;
  logic [W-1:0] count_out, ev_data;
  logic         locked, wrap_pulse, delta_err, ev_valid, ev_overrun;

  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] wrap_q[$];
  logic [W-1:0] rec_q[$];
  logic [3:0]   v, nv;
  int           exp_c;

  always #5 clk = ~clk;

  ripple_count_monitor #(.EXT_W(W), .STABLE_N(2), .MAX_STEP(4)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .clear(clear),
    .count_out(count_out), .locked(locked), .wrap_pulse(wrap_pulse),
    .delta_err(delta_err), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_data(ev_data), .ev_overrun(ev_overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] val);
    q_in = val;
    repeat (4) tick();
  endtask

  // monitor: pops expectations whenever the DUT shows a wrap or a record handshake
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (wrap_pulse === 1'b1) begin
      if (wrap_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wrap_unexpected: got wrap at count %0d, expected none", count_out);
      end else begin
        e = wrap_q.pop_front();
        check("wrap_count", int'(count_out), int'(e));
      end
    end
    if (ev_valid === 1'b1 && ev_ready === 1'b1) begin
      if (rec_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL record_unexpected: got record %0d, expected none", ev_data);
      end else begin
        e = rec_q.pop_front();
        check("record_data", int'(ev_data), int'(e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear = 1'b0; ev_ready = 1'b0; q_in = 4'd5;
    repeat (3) tick();
    check("rst_count", int'(count_out), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_wrap", int'(wrap_pulse), 0);
    check("rst_delta_err", int'(delta_err), 0);
    check("rst_ev_valid", int'(ev_valid), 0);
    check("rst_ev_data", int'(ev_data), 0);
    check("rst_overrun", int'(ev_overrun), 0);
    rst = 1'b0;

    repeat (3) tick();
    check("locked_edge2", int'(locked), 0);
    tick();
    check("locked_edge3", int'(locked), 1);
    check("baseline_count", int'(count_out), 0);

    q_in = 4'd6;
    repeat (3) tick();
    check("count_edge2", int'(count_out), 0);
    tick();
    check("count_edge3", int'(count_out), 1);

    step(4'd10); check("count_6_10", int'(count_out), 5);
    step(4'd14); repeat (2) tick(); check("count_14", int'(count_out), 9);
    step(4'd15); repeat (2) tick(); check("count_15", int'(count_out), 10);
    wrap_q.push_back(W'(11)); rec_q.push_back(W'(11));
    step(4'd0);
    check("count_0", int'(count_out), 11);
    check("wrap_hi", int'(wrap_pulse), 1);
    check("rec_valid", int'(ev_valid), 1);
    check("rec_data", int'(ev_data), 11);
    tick();
    check("wrap_lo", int'(wrap_pulse), 0);
    tick();
    step(4'd1); repeat (2) tick();
    check("count_1", int'(count_out), 12);

    step(4'd5); step(4'd9); step(4'd13);
    check("count_13", int'(count_out), 24);
    wrap_q.push_back(W'(28));
    step(4'd1);
    check("count_2nd_wrap", int'(count_out), 28);
    check("overrun_set", int'(ev_overrun), 1);
    check("rec_retained", int'(ev_data), 11);
    check("rec_still_valid", int'(ev_valid), 1);
    ev_ready = 1'b1;
    tick();
    check("rec_drained", int'(ev_valid), 0);

    step(4'd2);
    check("count_2", int'(count_out), 29);
    check("delta_err_clean", int'(delta_err), 0);
    step(4'd10);
    check("count_jump8", int'(count_out), 37);
    check("delta_err_jump", int'(delta_err), EXP_ERR);

    wrap_q.push_back(W'(46)); rec_q.push_back(W'(46));
    step(4'd3);
    check("count_10_3", int'(count_out), 46);
    q_in = 4'd7;
    tick();
    q_in = 4'd3;
    repeat (8) tick();
    check("glitch_ignored", int'(count_out), 46);

    v = 4'd3; exp_c = 46;
    for (int i = 0; i < 52; i++) begin
      nv = v + 4'd4;
      exp_c += 4;
      if (nv < v) begin
        wrap_q.push_back(W'(exp_c));
        rec_q.push_back(W'(exp_c));
      end
      step(nv);
      v = nv;
    end
    check("count_254", int'(count_out), 254);
    step(4'd4);
    check("count_max", int'(count_out), 255);
    step(4'd5);
    check("count_rollover", int'(count_out), 0);

    ev_ready = 1'b0;
    step(4'd9); step(4'd13);
    wrap_q.push_back(W'(12));
    step(4'd1);
    check("pend_data", int'(ev_data), 12);
    step(4'd5); step(4'd9); step(4'd13);
    wrap_q.push_back(W'(28));
    step(4'd1);
    check("pend_overrun", int'(ev_overrun), 1);
    check("pend_kept", int'(ev_data), 12);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_count", int'(count_out), 0);
    check("clr_locked", int'(locked), 0);
    check("clr_wrap", int'(wrap_pulse), 0);
    check("clr_delta_err", int'(delta_err), 0);
    check("clr_ev_valid", int'(ev_valid), 0);
    check("clr_ev_data", int'(ev_data), 0);
    check("clr_overrun", int'(ev_overrun), 0);
    tick();
    check("rebase_pending", int'(locked), 0);
    tick();
    check("rebase_locked", int'(locked), 1);
    check("rebase_count", int'(count_out), 0);
    step(4'd3);
    check("rebase_step", int'(count_out), 2);

    repeat (4) tick();
    check("wraps_all_seen", wrap_q.size(), 0);
    check("records_all_seen", rec_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
